// File: rtl/ram_rec_play_arb_pkg.sv
// Shared definitions for the record/playback RAM arbiter.
//   ADDR_W          : width of the RAM wrapper word address (26 bits)
//   DATA_W_DEFAULT  : default sample width (16 bits)
//   ST_*            : FSM state encodings, carried as state_t
package ram_rec_play_arb_pkg;

  localparam int ADDR_W         = 26;
  localparam int DATA_W_DEFAULT = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_WRITE     = 3'd1;
  localparam state_t ST_READ_REQ  = 3'd2;
  localparam state_t ST_READ_WAIT = 3'd3;
  localparam state_t ST_READ_ACK  = 3'd4;

endpackage

// File: rtl/ram_rec_play_arb.sv
// Arbitrates a single-port RAM wrapper between a sample recorder and a
// sample player. Recording has priority; each transaction is one FSM pass
// (IDLE -> WRITE, or IDLE -> READ_REQ -> READ_WAIT -> READ_ACK).
//
// Ports
//   sys_clk, reset          : clock, synchronous active-high reset
//   rec_valid/rec_data/rec_ready : record-sample handshake (one-deep buffer)
//   rec_clear               : pulse, empties the recording (applied in IDLE)
//   play_en, play_tick      : playback enable level, per-sample fetch strobe
//   play_data, play_valid   : fetched sample, valid for one cycle
//   ram_*                   : RAM wrapper command outputs / status inputs
//   max_ram_address         : last usable RAM address
//   rec_len                 : number of recorded samples
//   rec_full, play_underrun, rd_err, play_done : sticky status flags
//
// Build option: define LOOP_PLAYBACK_EN to wrap playback at the end of the
// recording instead of stopping with play_done.
module ram_rec_play_arb
  import ram_rec_play_arb_pkg::*;
#(
  parameter int DATA_BIT_WIDTH = DATA_W_DEFAULT,
  parameter int RD_TIMEOUT     = 255
) (
  input  logic                      sys_clk,
  input  logic                      reset,
  input  logic                      rec_valid,
  input  logic [DATA_BIT_WIDTH-1:0] rec_data,
  output logic                      rec_ready,
  input  logic                      rec_clear,
  input  logic                      play_en,
  input  logic                      play_tick,
  output logic [DATA_BIT_WIDTH-1:0] play_data,
  output logic                      play_valid,
  output logic [ADDR_W-1:0]         ram_address,
  output logic [DATA_BIT_WIDTH-1:0] ram_data_in,
  output logic                      ram_write_enable,
  output logic                      ram_read_request,
  output logic                      ram_read_ack,
  input  logic [DATA_BIT_WIDTH-1:0] ram_data_out,
  input  logic                      ram_rdy,
  input  logic                      ram_rd_data_pres,
  input  logic [ADDR_W-1:0]         max_ram_address,
  output logic [ADDR_W-1:0]         rec_len,
  output logic                      rec_full,
  output logic                      play_underrun,
  output logic                      rd_err,
  output logic                      play_done
);

  localparam int CNT_W = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT);

  state_t                    state;
  logic [DATA_BIT_WIDTH-1:0] rec_buf;
  logic                      rec_buf_full;
  logic [ADDR_W-1:0]         rec_ptr;
  logic [ADDR_W-1:0]         play_ptr;
  logic [ADDR_W-1:0]         rd_addr;
  logic                      play_pending;
  logic                      clr_pend;
  logic                      play_en_p1;
  logic [CNT_W-1:0]          wait_cnt;

  logic              in_idle;
  logic              clear_now;
  logic              rec_accept;
  logic              tick_eff;
  logic              play_fall;
  logic              wr_at_max;
  logic [ADDR_W-1:0] play_ptr_inc;

  assign in_idle      = (state == ST_IDLE);
  assign clear_now    = in_idle && (rec_clear || clr_pend);
  assign rec_ready    = ~reset & ram_rdy & ~rec_buf_full & ~rec_full;
  assign rec_accept   = rec_valid & rec_ready;
  assign tick_eff     = play_tick & play_en & ~play_done;
  assign play_fall    = play_en_p1 & ~play_en;
  assign wr_at_max    = (rec_ptr == max_ram_address);
  assign play_ptr_inc = play_ptr + ADDR_W'(1);
  assign ram_data_in  = rec_buf;

  // Strobes decode straight from the state register; gating with reset
  // guarantees no ack escapes when a read is abandoned by reset.
  always_comb begin
    ram_write_enable = 1'b0;
    ram_read_request = 1'b0;
    ram_read_ack     = 1'b0;
    ram_address      = '0;
    if (!reset) begin
      case (state)
        ST_WRITE: begin
          ram_write_enable = 1'b1;
          ram_address      = rec_ptr;
        end
        ST_READ_REQ: begin
          ram_read_request = 1'b1;
          ram_address      = play_ptr;
        end
        // Address is held through the ack: the wrapper picks the data lane
        // from address[0].
        ST_READ_WAIT: ram_address = rd_addr;
        ST_READ_ACK: begin
          ram_read_ack = 1'b1;
          ram_address  = rd_addr;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      rec_buf       <= '0;
      rec_buf_full  <= 1'b0;
      rec_ptr       <= '0;
      rec_len       <= '0;
      play_ptr      <= '0;
      rd_addr       <= '0;
      play_pending  <= 1'b0;
      clr_pend      <= 1'b0;
      play_en_p1    <= 1'b0;
      wait_cnt      <= '0;
      play_data     <= '0;
      play_valid    <= 1'b0;
      rec_full      <= 1'b0;
      play_underrun <= 1'b0;
      rd_err        <= 1'b0;
      play_done     <= 1'b0;
    end else begin
      play_valid <= 1'b0;
      play_en_p1 <= play_en;

      if (rec_accept) begin
        rec_buf      <= rec_data;
        rec_buf_full <= 1'b1;
      end

      if (rec_clear && !in_idle) clr_pend <= 1'b1;

      // A second tick while one is still outstanding is dropped.
      if (tick_eff) begin
        if (play_pending) play_underrun <= 1'b1;
        else              play_pending  <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (clear_now) begin
            rec_ptr   <= '0;
            rec_len   <= '0;
            rec_full  <= 1'b0;
            play_ptr  <= '0;
            play_done <= 1'b0;
            clr_pend  <= 1'b0;
          end else if (ram_rdy) begin
            if (rec_buf_full)
              state <= ST_WRITE;
            else if (play_pending && (play_ptr < rec_len))
              state <= ST_READ_REQ;
          end
        end
        ST_WRITE: begin
          rec_buf_full <= 1'b0;
          rec_len      <= rec_len + ADDR_W'(1);
          if (wr_at_max) rec_full <= 1'b1;
          else           rec_ptr  <= rec_ptr + ADDR_W'(1);
          state <= ST_IDLE;
        end
        ST_READ_REQ: begin
          rd_addr  <= play_ptr;
          wait_cnt <= '0;
          state    <= ST_READ_WAIT;
        end
        ST_READ_WAIT: begin
          if (ram_rd_data_pres) begin
            state <= ST_READ_ACK;
          end else if (wait_cnt == CNT_W'(RD_TIMEOUT - 1)) begin
            rd_err       <= 1'b1;
            play_pending <= 1'b0;
            state        <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ST_READ_ACK: begin
          play_data    <= ram_data_out;
          play_valid   <= 1'b1;
          play_pending <= 1'b0;
          state        <= ST_IDLE;
          // If playback was stopped while the read was in flight the data is
          // still delivered, but the pointer stays rewound.
          if (play_en) begin
`ifdef LOOP_PLAYBACK_EN
            play_ptr <= (play_ptr_inc >= rec_len) ? '0 : play_ptr_inc;
`else
            play_ptr <= play_ptr_inc;
            if (play_ptr_inc >= rec_len) play_done <= 1'b1;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (play_fall) begin
        play_ptr  <= '0;
        play_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram_rec_play_arb.sv
// Self-checking bench for ram_rec_play_arb. Contains a RAM wrapper model
// (read data returned 3 cycles after the request, held until the ack), a
// strobe monitor and a transaction-level scoreboard: every accepted sample
// is expected at the next sequential RAM address, and playback must return
// the accepted samples in order (wrapping when LOOP_PLAYBACK_EN is defined).
module tb_ram_rec_play_arb;

  localparam int DW = 16;
  localparam int AW = 26;
  localparam int TO = 255;
`ifdef LOOP_PLAYBACK_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic          sys_clk = 1'b0;
  logic          reset = 1'b1;
  logic          rec_valid = 1'b0;
  logic [DW-1:0] rec_data = '0;
  logic          rec_ready;
  logic          rec_clear = 1'b0;
  logic          play_en = 1'b0;
  logic          play_tick = 1'b0;
  logic [DW-1:0] play_data;
  logic          play_valid;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data_in;
  logic          ram_write_enable;
  logic          ram_read_request;
  logic          ram_read_ack;
  logic [DW-1:0] ram_data_out = '0;
  logic          ram_rdy = 1'b1;
  logic          ram_rd_data_pres = 1'b0;
  logic [AW-1:0] max_ram_address = 26'd1000;
  logic [AW-1:0] rec_len;
  logic          rec_full;
  logic          play_underrun;
  logic          rd_err;
  logic          play_done;

  ram_rec_play_arb #(.DATA_BIT_WIDTH(DW), .RD_TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .reset(reset),
    .rec_valid(rec_valid), .rec_data(rec_data), .rec_ready(rec_ready),
    .rec_clear(rec_clear), .play_en(play_en), .play_tick(play_tick),
    .play_data(play_data), .play_valid(play_valid),
    .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_write_enable(ram_write_enable), .ram_read_request(ram_read_request),
    .ram_read_ack(ram_read_ack), .ram_data_out(ram_data_out),
    .ram_rdy(ram_rdy), .ram_rd_data_pres(ram_rd_data_pres),
    .max_ram_address(max_ram_address), .rec_len(rec_len),
    .rec_full(rec_full), .play_underrun(play_underrun),
    .rd_err(rd_err), .play_done(play_done)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- RAM wrapper model, monitor, scoreboard ----------------
  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] acc_q[$];
  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];
  int            ev_q[$];
  int            reads = 0, acks = 0, pv_cnt = 0, p = 0, strobe_viol = 0;
  bit            resp_en = 1'b1;
  bit            rd_busy = 1'b0;
  int            rd_dly = 0;
  logic [AW-1:0] rd_a = '0;
  bit            we_q = 0, rr_q = 0, ra_q = 0, pv_q = 0;

  always @(negedge sys_clk) begin
    if (reset) begin
      rd_busy = 1'b0;
      ram_rd_data_pres = 1'b0;
      we_q = 0; rr_q = 0; ra_q = 0; pv_q = 0;
    end else begin
      if ((int'(ram_write_enable) + int'(ram_read_request) + int'(ram_read_ack)) > 1) strobe_viol++;
      if ((ram_write_enable && we_q) || (ram_read_request && rr_q) || (ram_read_ack && ra_q)) strobe_viol++;
      if (play_valid && pv_q) strobe_viol++;
      we_q = ram_write_enable; rr_q = ram_read_request; ra_q = ram_read_ack; pv_q = play_valid;

      if (rec_valid && rec_ready) acc_q.push_back(rec_data);
      if (ram_write_enable) begin
        mem[ram_address[9:0]] = ram_data_in;
        wr_addr_q.push_back(ram_address);
        wr_data_q.push_back(ram_data_in);
        ev_q.push_back(1);
      end
      if (ram_read_ack) begin
        acks++;
        rd_busy = 1'b0;
        ram_rd_data_pres = 1'b0;
      end else if (rd_busy) begin
        rd_dly++;
        if (rd_dly >= 3 && resp_en) begin
          ram_rd_data_pres = 1'b1;
          ram_data_out = mem[rd_a[9:0]];
        end
      end
      if (ram_read_request) begin
        reads++;
        ev_q.push_back(2);
        rd_busy = 1'b1;
        rd_dly = 0;
        rd_a = ram_address;
      end

      if (play_valid) begin
        pv_cnt++;
        chk("sb_play_data", play_data, (p < acc_q.size()) ? 32'(acc_q[p]) : 32'hDEAD_BEEF);
        p++;
        if (LOOP && p >= wr_addr_q.size()) p = 0;
        chk("sb_play_done", play_done, (!LOOP && p >= wr_addr_q.size()));
      end
    end
  end

  // ---------------- stimulus helpers (drive #1 after posedge) ----------------
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; rec_valid = 0; rec_clear = 0; play_en = 0; play_tick = 0;
    resp_en = 1'b1; ram_rdy = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    acc_q.delete(); wr_addr_q.delete(); wr_data_q.delete(); ev_q.delete();
    p = 0; reads = 0; acks = 0; pv_cnt = 0;
    tick();
  endtask

  task automatic send_sample(input logic [DW-1:0] d, output bit ok);
    bit rdy;
    ok = 1'b0;
    rec_valid = 1'b1;
    rec_data = d;
    for (int n = 0; n < 20; n++) begin
      rdy = rec_ready;
      tick();
      if (rdy) begin ok = 1'b1; break; end
    end
    rec_valid = 1'b0;
  endtask

  task automatic pulse_tick();
    play_tick = 1'b1;
    tick();
    play_tick = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!play_valid && n < 40) begin tick(); n++; end
    chk(name, play_valid, 1'b1);
  endtask

  typedef struct {
    logic [AW-1:0] max_addr;
    int            n_send;
    logic [AW-1:0] exp_len;
    logic          exp_full;
  } rec_vec_t;

  rec_vec_t vecs[5];

  initial begin
    bit ok;
    int n;
    vecs[0] = '{26'd1000, 4, 26'd4, 1'b0};
    vecs[1] = '{26'd3,    5, 26'd4, 1'b1};
    vecs[2] = '{26'd0,    2, 26'd1, 1'b1};
    vecs[3] = '{26'd1,    2, 26'd2, 1'b1};
    vecs[4] = '{26'd5,    3, 26'd3, 1'b0};

    // Reset state
    repeat (3) tick();
    chk("rst_rec_ready", rec_ready, 1'b0);
    chk("rst_strobes", {ram_write_enable, ram_read_request, ram_read_ack}, 3'b000);
    reset = 1'b0;
    tick();
    chk("rst_rec_len", rec_len, 0);
    chk("rst_flags", {rec_full, play_underrun, rd_err, play_done}, 4'b0000);
    chk("rst_play", {play_valid, play_data}, 0);
    chk("rst_rec_ready_after", rec_ready, 1'b1);

    // Table: record n samples against a given max address, then clear
    foreach (vecs[i]) begin
      do_reset();
      max_ram_address = vecs[i].max_addr;
      for (int k = 0; k < vecs[i].n_send; k++) send_sample(16'(16'h1111 * (k + 1)), ok);
      repeat (6) tick();
      chk("tbl_rec_len", rec_len, vecs[i].exp_len);
      chk("tbl_rec_full", rec_full, vecs[i].exp_full);
      chk("tbl_rec_ready", rec_ready, !vecs[i].exp_full);
      chk("tbl_wr_count", wr_addr_q.size(), vecs[i].exp_len);
      for (int k = 0; k < wr_addr_q.size(); k++) begin
        chk("tbl_wr_addr", wr_addr_q[k], k);
        chk("tbl_wr_data", wr_data_q[k], 16'(16'h1111 * (k + 1)));
      end
      rec_clear = 1'b1;
      tick();
      rec_clear = 1'b0;
      repeat (2) tick();
      chk("tbl_clr_len", rec_len, 0);
      chk("tbl_clr_full", rec_full, 1'b0);
      chk("tbl_clr_ready", rec_ready, 1'b1);
    end

    // Record 4 then play 4
    do_reset();
    max_ram_address = 26'd1000;
    for (int k = 0; k < 4; k++) send_sample(16'(16'h1111 * (k + 1)), ok);
    repeat (4) tick();
    chk("rp_rec_len", rec_len, 4);
    play_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pulse_tick();
      wait_valid("rp_valid");
      chk("rp_play_data", play_data, 16'(16'h1111 * (k + 1)));
      tick();
    end
    tick();
    chk("rp_play_done", play_done, !LOOP);

    // Record and tick in the same cycle: write first, then read
    do_reset();
    play_en = 1'b1;
    rec_valid = 1'b1; rec_data = 16'hABCD; play_tick = 1'b1;
    tick();
    rec_valid = 1'b0; play_tick = 1'b0;
    wait_valid("same_valid");
    chk("same_data", play_data, 16'hABCD);
    chk("same_ev0", (ev_q.size() > 0) ? ev_q[0] : 0, 1);
    chk("same_ev1", (ev_q.size() > 1) ? ev_q[1] : 0, 2);

    // Two ticks before the read completes
    do_reset();
    send_sample(16'h7777, ok);
    repeat (3) tick();
    play_en = 1'b1;
    pulse_tick();
    pulse_tick();
    wait_valid("ur_valid");
    repeat (10) tick();
    chk("ur_flag", play_underrun, 1'b1);
    chk("ur_reads", reads, 1);

    // Clear and a new sample in the same cycle
    do_reset();
    send_sample(16'h0101, ok);
    send_sample(16'h0202, ok);
    repeat (3) tick();
    rec_clear = 1'b1; rec_valid = 1'b1; rec_data = 16'h5A5A;
    tick();
    rec_clear = 1'b0; rec_valid = 1'b0;
    repeat (4) tick();
    chk("cv_rec_len", rec_len, 1);
    chk("cv_wr_addr", (wr_addr_q.size() == 3) ? 32'(wr_addr_q[2]) : 32'hFFFF_FFFF, 0);
    chk("cv_wr_data", (wr_data_q.size() == 3) ? 32'(wr_data_q[2]) : 32'hFFFF_FFFF, 16'h5A5A);

    // Read timeout, then recovery
    do_reset();
    send_sample(16'h9999, ok);
    repeat (3) tick();
    resp_en = 1'b0;
    play_en = 1'b1;
    pulse_tick();
    n = 0;
    while (!ram_read_request && n < 20) begin tick(); n++; end
    chk("to_req_seen", ram_read_request, 1'b1);
    repeat (TO) tick();
    chk("to_rd_err_before", rd_err, 1'b0);
    tick();
    chk("to_rd_err", rd_err, 1'b1);
    resp_en = 1'b1;
    tick();
    pulse_tick();
    wait_valid("to_recover_valid");
    chk("to_recover_data", play_data, 16'h9999);

    // Reset in the middle of a read: no ack
    do_reset();
    send_sample(16'h4242, ok);
    repeat (3) tick();
    resp_en = 1'b0;
    play_en = 1'b1;
    pulse_tick();
    repeat (8) tick();
    chk("mr_reads", reads, 1);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    resp_en = 1'b1;
    repeat (10) tick();
    chk("mr_acks", acks, 0);
    chk("mr_rd_err", rd_err, 1'b0);

    // Randomized traffic
    do_reset();
    max_ram_address = 26'd1000;
    play_en = 1'b1;
    for (int c = 0; c < 600; c++) begin
      ram_rdy   = ($urandom_range(0, 3) != 0);
      rec_valid = ($urandom_range(0, 1) == 1);
      rec_data  = 16'($urandom);
      play_tick = ($urandom_range(0, 7) == 0);
      tick();
    end
    rec_valid = 1'b0; play_tick = 1'b0; ram_rdy = 1'b1;
    repeat (60) tick();
    chk("rnd_rec_len", rec_len, acc_q.size());
    chk("rnd_wr_count", wr_addr_q.size(), acc_q.size());
    for (int i = 0; i < wr_addr_q.size() && i < acc_q.size(); i++) begin
      chk("rnd_wr_addr", wr_addr_q[i], i);
      chk("rnd_wr_data", wr_data_q[i], acc_q[i]);
    end
    chk("rnd_reads_vs_plays", reads, pv_cnt);
    chk("strobe_rules", strobe_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_rec_play_arb.md
RAM_REC_PLAY_ARB -- requirements
Module: ram_rec_play_arb

Interface
REQ-001 Parameter DATA_BIT_WIDTH, default 16: sample width; must equal the RAM wrapper data width.
REQ-002 Parameter RD_TIMEOUT, default 255: maximum cycles spent in READ_WAIT before abort.
REQ-003 sys_clk  in  1  sole clock; RAM wrapper user port runs on the same clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 rec_valid  in  1 / rec_data  in  DATA_BIT_WIDTH / rec_ready  out  1: record-sample valid/ready handshake.
REQ-006 rec_clear  in  1: pulse; empties the recording (rec_ptr and rec_len go to 0).
REQ-007 play_en  in  1 / play_tick  in  1: playback enable level and per-sample fetch strobe.
REQ-008 play_data  out  DATA_BIT_WIDTH / play_valid  out  1: fetched sample, valid for one cycle.
REQ-009 ram_address  out  26 / ram_data_in  out  DATA_BIT_WIDTH / ram_write_enable  out  1 / ram_read_request  out  1 / ram_read_ack  out  1: RAM wrapper command outputs.
REQ-010 ram_data_out  in  DATA_BIT_WIDTH / ram_rdy  in  1 / ram_rd_data_pres  in  1 / max_ram_address  in  26: RAM wrapper status inputs.
REQ-011 rec_len  out  26: number of recorded samples.
REQ-012 rec_full, play_underrun, rd_err, play_done  out  1 each: sticky status flags.

Function
REQ-013 FSM states IDLE, WRITE, READ_REQ, READ_WAIT, READ_ACK; exactly one state is active per cycle.
REQ-014 rec_ready = ram_rdy & ~rec_buf_full & ~rec_full; on rec_valid & rec_ready the sample is latched into a one-deep record buffer.
REQ-015 play_tick & play_en & ~play_done sets play_pending; if play_tick occurs while play_pending is already set, play_underrun is set and the tick is dropped.
REQ-016 IDLE: stay while ~ram_rdy; if rec_buf_full go to WRITE (record has priority); else if play_pending and play_ptr < rec_len go to READ_REQ.
REQ-017 WRITE: one cycle with ram_write_enable=1, ram_address=rec_ptr, ram_data_in=buffer; rec_ptr, rec_len += 1, buffer cleared, next IDLE.
REQ-018 On the write that targets ram_address == max_ram_address, rec_full is set and rec_ptr does not increment; rec_ready stays 0 until rec_clear.
REQ-019 READ_REQ: one cycle with ram_read_request=1, ram_address=play_ptr; next READ_WAIT.
REQ-020 READ_WAIT: ram_address holds play_ptr; on ram_rd_data_pres go to READ_ACK; after RD_TIMEOUT cycles without it, set rd_err, clear play_pending, go IDLE.
REQ-021 READ_ACK: one cycle with ram_read_ack=1 and ram_address still play_ptr, because wrapper data lane selection depends on address[0].
REQ-022 In READ_ACK, play_data <= ram_data_out and play_valid pulses on the following cycle; play_ptr += 1; play_pending cleared; next IDLE.
REQ-023 ram_write_enable, ram_read_request and ram_read_ack are mutually exclusive and each is high for at most one cycle per transaction.
REQ-024 play_en falling edge: play_ptr <= 0 and play_done cleared; an in-flight read still completes.
REQ-025 rec_clear is honoured only in IDLE (otherwise held pending until IDLE); it clears rec_ptr, rec_len, rec_full, play_ptr and play_done.
REQ-026 If rec_clear and rec_valid arrive in the same cycle, the clear applies first, then the sample is accepted at address 0.

Reset
REQ-027 Reset: state=IDLE; all pointers, rec_len, buffers and flags =0; all RAM strobes=0; play_data=0; play_valid=0; rec_ready=0 during reset.
REQ-028 Reset asserted mid-read abandons the transaction without issuing ram_read_ack.

Configuration
REQ-029 Macro LOOP_PLAYBACK_EN defined: when play_ptr reaches rec_len, play_ptr wraps to 0 and playback continues; play_done never sets.
REQ-030 Macro LOOP_PLAYBACK_EN undefined: when play_ptr reaches rec_len, play_done is set and further ticks are ignored until play_en falls.

Structure
REQ-031 Shared package holds the FSM state enum, the 26-bit address width constant and the DATA_BIT_WIDTH default.
REQ-032 Single module, no sub-modules; the one-deep record buffer is inline.

Verification
REQ-033 Record 4 samples 0x1111..0x4444 with ram_rdy=1 -> 4 single-cycle write pulses at addresses 0..3; rec_len=4.
REQ-034 play_en=1 and 4 ticks, wrapper model returns data after 3 cycles -> play_data 0x1111..0x4444 in order; without LOOP_PLAYBACK_EN play_done=1 after the 4th sample.
REQ-035 rec_valid and play_tick in the same cycle -> write issued first, read follows; no strobe overlap.
REQ-036 Two play_ticks before the read completes -> play_underrun=1 and exactly one read is issued.
REQ-037 ram_rd_data_pres held 0 -> rd_err=1 after 255 READ_WAIT cycles; FSM returns to IDLE.
REQ-038 max_ram_address=3, record 5 samples -> rec_full after address 3; rec_ready=0; rec_clear restores rec_ready=1 and rec_len=0.
